// File: rtl/vga_bus_master.sv
// Bus-initiator fill/copy engine for the VGA video-memory window.
// Drives 8086-style _vga_mem/_rd/_wr/_bhe cycles with rdy wait states and a strobe timeout.
module vga_bus_master #(
  parameter int unsigned STROBE_MIN = 4,
  parameter int unsigned WAIT_MAX   = 255,
  parameter int unsigned AW         = 17
) (
  input  logic          clock,
  input  logic          _reset,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] src_addr,
  input  logic [15:0]   count,
  input  logic [15:0]   pattern,
  input  logic [1:0]    mask,
  input  logic          abort,
  input  logic          rdy,
  input  logic [15:0]   din,
  output logic [AW-1:0] bus_addr,
  output logic [15:0]   dout,
  output logic          dout_en,
  output logic          _vga_mem,
  output logic          _rd,
  output logic          _wr,
  output logic          _bhe,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          err,
  output logic [15:0]   remaining
);

  localparam int unsigned ScW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StRecover, StDone} state_e;

  state_e          state_q, state_d;
  logic            rdy_s;
  logic            op_q, rd_phase_q, abort_q;
  logic [AW-1:0]   dst_q, src_q;
  logic [15:0]     pattern_q, buf_q, remaining_q;
  logic [1:0]      mask_q;
  logic [ScW-1:0]  sc_q;
  logic            err_q, aborted_q;

  logic            in_access, abort_any, strobe_exit, timeout;
  logic [AW-1:0]   wr_addr;

  assign in_access   = state_q inside {StSetup, StStrobe, StRecover};
  assign abort_any   = abort_q | (abort & in_access);
  assign strobe_exit = (sc_q >= ScW'(STROBE_MIN - 1)) && rdy_s;
  assign timeout     = (sc_q == ScW'(WAIT_MAX)) && !strobe_exit;
  // A0 is only set for a high-byte-only write.
  assign wr_addr     = {dst_q[AW-1:1], mask_q == 2'b10};

  always_ff @(posedge clock) begin
    if (!_reset) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (mask == 2'b00 || count == 16'd0) ? StDone : StSetup;
      end
      StSetup:  state_d = StStrobe;
      StStrobe: begin
        if (strobe_exit)  state_d = StRecover;
        else if (timeout) state_d = StDone;
      end
      StRecover: begin
        if (rd_phase_q)                              state_d = abort_any ? StDone : StSetup;
        else if (remaining_q == 16'd1 || abort_any)  state_d = StDone;
        else                                         state_d = StSetup;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!_reset) begin
      rdy_s       <= 1'b0;
      op_q        <= 1'b0;
      rd_phase_q  <= 1'b0;
      abort_q     <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      pattern_q   <= '0;
      buf_q       <= '0;
      remaining_q <= '0;
      mask_q      <= '0;
      sc_q        <= '0;
      err_q       <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      rdy_s <= rdy;
      if (in_access && abort) abort_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q        <= op;
            rd_phase_q  <= op;
            dst_q       <= {dst_addr[AW-1:1], 1'b0};
            src_q       <= {src_addr[AW-1:1], 1'b0};
            pattern_q   <= pattern;
            mask_q      <= mask;
            remaining_q <= count;
            err_q       <= (mask == 2'b00);
            aborted_q   <= 1'b0;
            abort_q     <= 1'b0;
          end
        end
        StSetup: sc_q <= '0;
        StStrobe: begin
          sc_q <= sc_q + 1'b1;
          if (strobe_exit && rd_phase_q) buf_q <= din;
          if (timeout) begin
            err_q <= 1'b1;
            if (abort_any) aborted_q <= 1'b1;
          end
        end
        StRecover: begin
          if (rd_phase_q) begin
            rd_phase_q <= 1'b0;
          end else begin
            dst_q       <= dst_q + AW'(2);
            src_q       <= src_q + AW'(2);
            remaining_q <= remaining_q - 16'd1;
            rd_phase_q  <= op_q;
          end
          if (state_d == StDone && abort_any) aborted_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_addr = '0;
    dout     = '0;
    dout_en  = 1'b0;
    _vga_mem = 1'b1;
    _rd      = 1'b1;
    _wr      = 1'b1;
    _bhe     = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StSetup, StStrobe, StRecover: begin
        busy     = 1'b1;
        _vga_mem = 1'b0;
        if (rd_phase_q) begin
          // Copy reads always fetch the full word.
          bus_addr = src_q;
          _bhe     = 1'b0;
        end else begin
          bus_addr = wr_addr;
          _bhe     = ~mask_q[1];
          dout     = op_q ? buf_q : pattern_q;
          dout_en  = 1'b1;
        end
        if (state_q == StStrobe) begin
          _rd = ~rd_phase_q;
          _wr = rd_phase_q;
        end
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign aborted   = aborted_q;
  assign err       = err_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_vga_bus_master.sv
// Directed bench for vga_bus_master: a negedge bus monitor records each strobe,
// and each test task compares recorded cycles and status against hand-computed values.
module tb_vga_bus_master;

  logic        clock, _reset, start, op, abort, rdy;
  logic [16:0] dst_addr, src_addr, bus_addr;
  logic [15:0] count, pattern, din, dout, remaining;
  logic [1:0]  mask;
  logic        dout_en, _vga_mem, _rd, _wr, _bhe, busy, done, aborted, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [16:0] addr;
    logic [15:0] data;
    logic        bhe;
    int          len;
  } rec_t;

  rec_t recs[$];
  rec_t cur;
  bit   in_strobe = 0;
  int   vm_cnt = 0, unstable = 0, overlap = 0;

  vga_bus_master #(.STROBE_MIN(4), .WAIT_MAX(255), .AW(17)) dut (
    .clock(clock), ._reset(_reset), .start(start), .op(op), .dst_addr(dst_addr),
    .src_addr(src_addr), .count(count), .pattern(pattern), .mask(mask), .abort(abort),
    .rdy(rdy), .din(din), .bus_addr(bus_addr), .dout(dout), .dout_en(dout_en),
    ._vga_mem(_vga_mem), ._rd(_rd), ._wr(_wr), ._bhe(_bhe), .busy(busy), .done(done),
    .aborted(aborted), .err(err), .remaining(remaining)
  );

  // Video-memory read model.
  assign din = (bus_addr == 17'h00000) ? 16'hAAAA :
               (bus_addr == 17'h00002) ? 16'h5555 : 16'hDEAD;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (_rd === 1'b0 && _wr === 1'b0) overlap++;
    if ((_rd === 1'b0 || _wr === 1'b0) && _vga_mem !== 1'b0) overlap++;
    if (_vga_mem === 1'b0) vm_cnt++;
    if (_rd === 1'b0 || _wr === 1'b0) begin
      if (!in_strobe) begin
        in_strobe = 1;
        cur.wr    = (_wr === 1'b0);
        cur.addr  = bus_addr;
        cur.data  = (_wr === 1'b0) ? dout : 16'h0;
        cur.bhe   = _bhe;
        cur.len   = 0;
      end else if (bus_addr !== cur.addr || (cur.wr && dout !== cur.data)) begin
        unstable++;
      end
      if (_wr === 1'b0 && dout_en !== 1'b1) unstable++;
      cur.len++;
    end else if (in_strobe) begin
      in_strobe = 0;
      recs.push_back(cur);
    end
  end

  function automatic logic [50:0] pack(input rec_t r);
    return {r.wr, r.addr, r.data, r.bhe, r.len[15:0]};
  endfunction

  task automatic run_cmd(input bit o, input logic [16:0] d, input logic [16:0] s,
                         input logic [15:0] c, input logic [15:0] p, input logic [1:0] m,
                         input int lo_s, input int lo_n, input int ab_at, input int rs_at,
                         input int budget, output int cyc, output bit seen,
                         output logic done_next);
    recs.delete();
    vm_cnt   = 0;
    unstable = 0;
    op = o; dst_addr = d; src_addr = s; count = c; pattern = p; mask = m;
    start = 1'b1;
    rdy   = (lo_n > 0 && lo_s == 0) ? 1'b0 : 1'b1;
    cyc   = 0;
    seen  = 0;
    while (!seen && cyc < budget) begin
      @(negedge clock);
      cyc++;
      start = (cyc == rs_at);
      if (start) begin
        dst_addr = 17'h00700;
        count    = 16'd9;
      end
      abort = (cyc == ab_at);
      rdy   = (cyc >= lo_s && cyc < lo_s + lo_n) ? 1'b0 : 1'b1;
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0; abort = 1'b0; rdy = 1'b1;
    @(negedge clock);
    done_next = done;
  endtask

  task automatic do_reset();
    _reset = 1'b0;
    repeat (2) @(negedge clock);
    _reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({_vga_mem, _rd, _wr, _bhe, dout_en, busy, done, aborted, err} !== 9'b111100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 111100000",
               {_vga_mem, _rd, _wr, _bhe, dout_en, busy, done, aborted, err});
    end
    checks++;
    if (bus_addr !== 17'h0 || dout !== 16'h0) begin
      errors++; $display("FAIL reset_bus: got %h/%h expected 0/0", bus_addr, dout);
    end
    checks++;
    if (remaining !== 16'h0) begin
      errors++; $display("FAIL reset_remaining: got %h expected 0", remaining);
    end
  endtask

  task automatic test_fill();
    int cyc; bit seen; logic dn;
    logic [50:0] got, exp;
    run_cmd(0, 17'h00100, 17'h0, 16'd4, 16'h1F41, 2'b11, 0, 0, -1, -1, 100, cyc, seen, dn);
    checks++;
    if (!seen) begin errors++; $display("FAIL fill_done_seen: got 0 expected 1"); end
    checks++;
    if (!(cyc >= 24 && cyc <= 25)) begin
      errors++; $display("FAIL fill_latency: got %0d expected 24..25", cyc);
    end
    checks++;
    if (dn !== 1'b0) begin errors++; $display("FAIL fill_done_pulse: got %b expected 0", dn); end
    checks++;
    if (recs.size() != 4) begin
      errors++; $display("FAIL fill_count: got %0d expected 4", recs.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < recs.size()) ? pack(recs[i]) : '1;
      exp = {1'b1, 17'h00100 + 17'(2 * i), 16'h1F41, 1'b0, 16'd4};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL fill_cycle%0d: got %h expected %h", i, got, exp); end
    end
    checks++;
    if (remaining !== 16'd0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL fill_status: got %h/%b/%b expected 0/0/0", remaining, err, busy);
    end
  endtask

  task automatic test_wait_states();
    int cyc; bit seen; logic dn;
    int exp_len[4] = '{4, 12, 4, 4};
    checks++;
    run_cmd(0, 17'h00200, 17'h0, 16'd4, 16'hC3C3, 2'b11, 8, 10, -1, -1, 100, cyc, seen, dn);
    if (cyc !== 33) begin errors++; $display("FAIL wait_latency: got %0d expected 33", cyc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= recs.size() || recs[i].len != exp_len[i]) begin
        errors++;
        $display("FAIL wait_len%0d: got %0d expected %0d", i,
                 (i < recs.size()) ? recs[i].len : -1, exp_len[i]);
      end
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL wait_stable: got %0d expected 0", unstable); end
  endtask

  task automatic test_byte_masks();
    int cyc; bit seen; logic dn;
    run_cmd(0, 17'h00300, 17'h0, 16'd2, 16'h00AB, 2'b10, 0, 0, -1, -1, 100, cyc, seen, dn);
    checks++;
    if (recs.size() != 2 || recs[0].addr !== 17'h00301 || recs[1].addr !== 17'h00303 ||
        recs[0].bhe !== 1'b0 || recs[1].bhe !== 1'b0) begin
      errors++; $display("FAIL mask10: got n=%0d a=%h bhe=%b expected n=2 a=00301 bhe=0",
                         recs.size(), recs[0].addr, recs[0].bhe);
    end
    run_cmd(0, 17'h00300, 17'h0, 16'd2, 16'h00AB, 2'b01, 0, 0, -1, -1, 100, cyc, seen, dn);
    checks++;
    if (recs.size() != 2 || recs[0].addr !== 17'h00300 || recs[1].addr !== 17'h00302 ||
        recs[0].bhe !== 1'b1 || recs[1].bhe !== 1'b1) begin
      errors++; $display("FAIL mask01: got n=%0d a=%h bhe=%b expected n=2 a=00300 bhe=1",
                         recs.size(), recs[0].addr, recs[0].bhe);
    end
    run_cmd(0, 17'h00300, 17'h0, 16'd2, 16'h00AB, 2'b00, 0, 0, -1, -1, 20, cyc, seen, dn);
    checks++;
    if (!seen || cyc != 1 || err !== 1'b1 || vm_cnt != 0) begin
      errors++; $display("FAIL mask00: got seen=%b cyc=%0d err=%b vm=%0d expected 1/1/1/0",
                         seen, cyc, err, vm_cnt);
    end
  endtask

  task automatic test_copy();
    int cyc; bit seen; logic dn;
    logic [50:0] got;
    logic [50:0] exp[4];
    exp[0] = {1'b0, 17'h00000, 16'h0000, 1'b0, 16'd4};
    exp[1] = {1'b1, 17'h08000, 16'hAAAA, 1'b0, 16'd4};
    exp[2] = {1'b0, 17'h00002, 16'h0000, 1'b0, 16'd4};
    exp[3] = {1'b1, 17'h08002, 16'h5555, 1'b0, 16'd4};
    run_cmd(1, 17'h08000, 17'h00000, 16'd2, 16'h0, 2'b11, 0, 0, -1, -1, 100, cyc, seen, dn);
    checks++;
    if (!seen || cyc != 25) begin
      errors++; $display("FAIL copy_latency: got %0d expected 25", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < recs.size()) ? pack(recs[i]) : '1;
      checks++;
      if (got !== exp[i]) begin
        errors++; $display("FAIL copy_cycle%0d: got %h expected %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_abort();
    int cyc; bit seen; logic dn;
    run_cmd(0, 17'h00400, 17'h0, 16'd4, 16'h7777, 2'b11, 0, 0, 3, -1, 100, cyc, seen, dn);
    checks++;
    if (!seen || cyc != 7 || aborted !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL abort_fill: got seen=%b cyc=%0d ab=%b err=%b expected 1/7/1/0",
                         seen, cyc, aborted, err);
    end
    checks++;
    if (recs.size() != 1 || recs[0].len != 4 || vm_cnt != 6) begin
      errors++; $display("FAIL abort_cycles: got n=%0d vm=%0d expected n=1 vm=6",
                         recs.size(), vm_cnt);
    end
    checks++;
    if (remaining !== 16'd3) begin
      errors++; $display("FAIL abort_remaining: got %0d expected 3", remaining);
    end
    run_cmd(1, 17'h08000, 17'h00000, 16'd2, 16'h0, 2'b11, 0, 0, 3, -1, 100, cyc, seen, dn);
    checks++;
    if (recs.size() != 1 || recs[0].wr !== 1'b0 || aborted !== 1'b1) begin
      errors++; $display("FAIL abort_copy: got n=%0d ab=%b expected n=1 read-only ab=1",
                         recs.size(), aborted);
    end
  endtask

  task automatic test_timeout();
    int cyc; bit seen; logic dn;
    run_cmd(0, 17'h00500, 17'h0, 16'd1, 16'h1234, 2'b11, 0, 100000, -1, -1, 400, cyc, seen, dn);
    checks++;
    if (!seen || cyc != 258 || err !== 1'b1 || aborted !== 1'b0) begin
      errors++; $display("FAIL timeout: got seen=%b cyc=%0d err=%b ab=%b expected 1/258/1/0",
                         seen, cyc, err, aborted);
    end
    checks++;
    if (recs.size() != 1 || recs[0].len != 256) begin
      errors++; $display("FAIL timeout_strobe: got n=%0d expected one 256-clock strobe",
                         recs.size());
    end
    run_cmd(0, 17'h00500, 17'h0, 16'd1, 16'h1234, 2'b11, 0, 100000, 10, -1, 400, cyc, seen, dn);
    checks++;
    if (!seen || err !== 1'b1 || aborted !== 1'b1) begin
      errors++; $display("FAIL timeout_abort: got err=%b ab=%b expected 1/1", err, aborted);
    end
  endtask

  task automatic test_reset_mid_strobe();
    op = 0; dst_addr = 17'h00600; count = 16'd4; pattern = 16'h4242; mask = 2'b11;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (_wr !== 1'b0) begin errors++; $display("FAIL rst_mid_pre: got _wr=%b expected 0", _wr); end
    _reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({_vga_mem, _rd, _wr, _bhe, busy, dout_en, remaining} !== {6'b111100, 16'h0}) begin
      errors++; $display("FAIL rst_mid: got %b rem=%h expected 111100 rem=0",
                         {_vga_mem, _rd, _wr, _bhe, busy, dout_en}, remaining);
    end
    _reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_edge_cases();
    int cyc; bit seen; logic dn;
    run_cmd(0, 17'h00100, 17'h0, 16'd0, 16'h1F41, 2'b11, 0, 0, -1, -1, 20, cyc, seen, dn);
    checks++;
    if (!seen || cyc != 1 || vm_cnt != 0 || err !== 1'b0) begin
      errors++; $display("FAIL count0: got seen=%b cyc=%0d vm=%0d err=%b expected 1/1/0/0",
                         seen, cyc, vm_cnt, err);
    end
    run_cmd(0, 17'h1FFFE, 17'h0, 16'd2, 16'h9999, 2'b11, 0, 0, -1, -1, 100, cyc, seen, dn);
    checks++;
    if (recs.size() != 2 || recs[0].addr !== 17'h1FFFE || recs[1].addr !== 17'h00000) begin
      errors++; $display("FAIL wrap: got n=%0d a1=%h expected n=2 a1=00000",
                         recs.size(), (recs.size() > 1) ? recs[1].addr : 17'h1ffff);
    end
    run_cmd(0, 17'h00600, 17'h0, 16'd2, 16'h1111, 2'b11, 0, 0, -1, 5, 100, cyc, seen, dn);
    checks++;
    if (!seen || cyc != 13 || recs.size() != 2 || recs[1].addr !== 17'h00602 ||
        remaining !== 16'd0) begin
      errors++; $display("FAIL start_busy: got cyc=%0d n=%0d rem=%0d expected 13/2/0",
                         cyc, recs.size(), remaining);
    end
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL strobe_rules: got %0d expected 0", overlap); end
  endtask

  initial begin
    _reset = 1'b0; start = 1'b0; op = 1'b0; abort = 1'b0; rdy = 1'b1;
    dst_addr = '0; src_addr = '0; count = '0; pattern = '0; mask = 2'b11;
    @(negedge clock);
    test_reset();
    test_fill();
    test_wait_states();
    test_byte_masks();
    test_copy();
    test_abort();
    test_timeout();
    test_reset_mid_strobe();
    test_edge_cases();
    test_strobe_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_bus_master.md
Name:
vga_bus_master

Overview:
- Blitter/fill engine that acts as a bus initiator toward the VGA video-memory window.
- It generates the same cycles the 8086 drives on the VGA controller's CPU port: _vga_mem, addr A0/A1, _bhe, _rd, _wr, with rdy as the wait input.
- It performs word fills and memory-to-memory copies into video RAM without CPU involvement, e.g. screen clear, attribute fill and scrolling.
- It sits on the system bus beside the CPU. External arbitration grants it the bus before start is asserted.

Parameters:
- STROBE_MIN, 4: minimum _rd/_wr low time in clocks, so the VGA synchroniser and write-delay logic always see the strobe.
- WAIT_MAX, 255: maximum STROBE clocks before a timeout error.
- AW, 17: byte-address width of the VGA window (15-bit RAM word address × 4 bytes).

Ports:
- clock  in  1  system clock (50 MHz).
- _reset  in  1  synchronous active-low reset; one clock, all logic on rising edge of clock.
- start  in  1  one-clock pulse; latches the command inputs; ignored while busy.
- op  in  1  0 = fill, 1 = copy.
- dst_addr  in  AW  destination byte address; bit 0 is forced to 0.
- src_addr  in  AW  source byte address for copy; bit 0 is forced to 0.
- count  in  16  number of words to transfer.
- pattern  in  16  fill word.
- mask  in  2  byte enable: bit0 = low byte, bit1 = high byte.
- abort  in  1  one-clock pulse requesting a stop.
- rdy  in  1  wait input from the VGA controller (0 = extend cycle).
- din  in  16  read data from the bus.
- bus_addr  out  AW  byte address driven on the bus.
- dout  out  16  write data.
- dout_en  out  1  data-bus drive enable (1 during write cycles, SETUP through RECOVER).
- _vga_mem  out  1  VGA window select, active low.
- _rd  out  1  read strobe, active low.
- _wr  out  1  write strobe, active low.
- _bhe  out  1  byte-high enable, active low.
- busy  out  1  operation in progress.
- done  out  1  one-clock pulse at completion, abort or error.
- aborted  out  1  sticky until next start: last operation was aborted.
- err  out  1  sticky until next start: timeout or mask = 00.
- remaining  out  16  words still to transfer.

Behaviour:
- Reset (_reset = 0 sampled at a clock edge):
  - next edge: _vga_mem = _rd = _wr = _bhe = 1, dout_en = 0, bus_addr = 0, dout = 0;
  - busy = done = aborted = err = 0, remaining = 0, state = IDLE;
  - a cycle in flight is dropped; the strobe is released immediately.
- rdy is registered once (rdy_s) before use.
- States and transitions:
  - IDLE: on start, latch the command and clear aborted/err.
    - mask = 00: err = 1, done pulse next clock, no bus cycle.
    - count = 0: done pulse next clock, no bus cycle.
    - otherwise: busy = 1, go to SETUP.
  - SETUP (1 clk):
    - bus_addr = src pointer (copy read phase) or dst pointer (write phase);
    - _vga_mem = 0;
    - A0/_bhe from mask: 11 → A0 = 0, _bhe = 0; 01 → A0 = 0, _bhe = 1; 10 → A0 = 1, _bhe = 0;
    - copy reads always use mask 11;
    - dout and dout_en are valid for writes.
  - STROBE:
    - _rd or _wr = 0; counter sc starts at 0 and increments each clock.
    - Exit when sc ≥ STROBE_MIN−1 and rdy_s = 1.
    - For reads, din is captured into the copy buffer on the exit clock.
    - If sc reaches WAIT_MAX: err = 1, strobe released, go to DONE.
  - RECOVER (1 clk): strobe = 1, address held, _vga_mem = 0. Next clock _vga_mem = 1.
    - Copy read phase done → SETUP (write phase).
    - Otherwise, after a write: dst += 2, src += 2 (copy), remaining −= 1.
    - remaining = 0 → DONE, else → SETUP.
  - DONE (1 clk): done = 1, busy = 0, all bus outputs idle → IDLE.
- Cycle length with rdy = 1:
  - fill: 6 clocks per word;
  - copy: 12 clocks per word.
- Pointers wrap modulo 2^AW; no error on wrap.
- abort:
  - in SETUP or STROBE: the current cycle completes with full strobe width and RECOVER, then DONE with aborted = 1;
  - a copy aborted after its read phase does not perform the write;
  - in IDLE: ignored.
- Simultaneous events:
  - abort together with timeout: err and aborted are both set.
  - start while busy: ignored, command inputs not relatched.
- Strobes never overlap; _rd and _wr are never both 0. _vga_mem stays low across SETUP–RECOVER of one access.

Test Plan:
- Fill: count = 4, dst = 0x00100, pattern = 0x1F41, mask = 11, rdy = 1 → four writes at 0x00100/0x00102/0x00104/0x00106, dout = 0x1F41, each _wr low exactly 4 clocks; done pulses 24–25 clocks after start; remaining = 0.
- Wait states: rdy forced 0 for 10 clocks during word 2 → that _wr stays low until 1 clock after rdy returns; bus_addr and dout stable throughout; other words keep 4-clock strobes.
- Byte masks:
  - mask = 10 → A0 = 1, _bhe = 0 on every cycle;
  - mask = 01 → A0 = 0, _bhe = 1;
  - mask = 00 → err = 1, done, no _vga_mem activity.
- Copy: count = 2, src = 0x00000, dst = 0x08000, model returns 0xAAAA, 0x5555 → order is read 0x00000, write 0x08000 = 0xAAAA, read 0x00002, write 0x08002 = 0x5555.
- Abort, timeout and reset:
  - abort on clock 2 of a STROBE → strobe still 4 clocks, no further cycles, aborted = 1, done = 1;
  - rdy held 0 → err after WAIT_MAX clocks;
  - _reset low mid-STROBE → all strobes/selects = 1, busy = 0 on the next edge.
- Edge cases:
  - count = 0 → done only, no bus activity;
  - dst = 0x1FFFE with count = 2 → second write at 0x00000.
